// File: rtl/wb_ram_burst.sv
// wb_ram_burst: Wishbone B3 RAM slave with byte-lane writes,
// registered-feedback incrementing bursts and address-range errors.
module wb_ram_burst #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_SIZE_BYTES = 32768,
    parameter int WINDOW_WIDTH   = 24
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH     = MEM_SIZE_BYTES / SEL_WIDTH;
    localparam int WORD_AW   = $clog2(DEPTH);
    localparam int BYTE_BITS = $clog2(SEL_WIDTH);
    localparam int W1        = WORD_AW + 1;
    localparam int WW1       = WINDOW_WIDTH + 1;

    localparam logic [WINDOW_WIDTH:0] MEM_LIM = WW1'(MEM_SIZE_BYTES);
    localparam logic [WORD_AW:0]      DEPTH_W = W1'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, BURST, ERR} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [WORD_AW-1:0]      adr_q;
    logic                    ack_q;
    logic                    err_q;

    logic [WINDOW_WIDTH-1:0] off;
    logic                    oor;
    logic [WORD_AW-1:0]      idx;
    logic [WORD_AW:0]        a_ext;
    logic [WORD_AW:0]        wrap_mask;
    logic [WORD_AW:0]        nxt;
    logic                    nxt_oor;
    logic                    wr_en;
    logic                    unused_adr;

    assign off        = wb_adr_i[WINDOW_WIDTH-1:0];
    assign oor        = {1'b0, off} >= MEM_LIM;
    assign idx        = off[BYTE_BITS +: WORD_AW];
    assign unused_adr = ^wb_adr_i;

    always_comb begin
        wrap_mask = '0;
        unique case (wb_bte_i)
            2'b01:   wrap_mask = W1'(3);
            2'b10:   wrap_mask = W1'(7);
            2'b11:   wrap_mask = W1'(15);
            default: wrap_mask = '0;
        endcase
    end

    // The extra top bit lets a linear step past the last word trip the range check.
    assign a_ext   = {1'b0, adr_q};
    assign nxt     = (wb_bte_i == 2'b00) ? a_ext + W1'(1)
                   : (a_ext & ~wrap_mask) | ((a_ext + W1'(1)) & wrap_mask);
    assign nxt_oor = nxt >= DEPTH_W;

    assign wr_en = !wb_rst_i && wb_cyc_i && wb_stb_i && wb_we_i && !oor
                 && (state == ACK || state == BURST);

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            adr_q <= '0;
        end else if (!wb_cyc_i) begin
            state <= IDLE;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wb_stb_i && !ack_q && !err_q) begin
                        if (oor) begin
                            state <= ERR;
                            err_q <= 1'b1;
                            dat_q <= '0;
                        end else begin
                            state <= ACK;
                            ack_q <= 1'b1;
                            dat_q <= mem[idx];
                            adr_q <= idx;
                        end
                    end
                end
                ACK, BURST: begin
                    if (!wb_stb_i || wb_cti_i != 3'b010) begin
                        state <= IDLE;
                        ack_q <= 1'b0;
                    end else if (nxt_oor) begin
                        state <= ERR;
                        ack_q <= 1'b0;
                        err_q <= 1'b1;
                        dat_q <= '0;
                    end else begin
                        state <= BURST;
                        ack_q <= 1'b1;
                        dat_q <= mem[nxt[WORD_AW-1:0]];
                        adr_q <= nxt[WORD_AW-1:0];
                    end
                end
                ERR: begin
                    state <= IDLE;
                    err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A dropped strobe mid-burst must suppress the ack in that same cycle.
    assign wb_ack_o = ack_q && (state != BURST || (wb_stb_i && wb_cyc_i));
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_ram_burst.sv
// tb_wb_ram_burst: directed and randomized checks of wb_ram_burst
// against a word-array reference model.
module tb_wb_ram_burst;
    localparam int MEM   = 1024;
    localparam int WORDS = MEM / 4;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [31:0] adr  = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel  = '0;
    logic        cyc  = 1'b0;
    logic        stb  = 1'b0;
    logic        we   = 1'b0;
    logic [2:0]  cti  = '0;
    logic [1:0]  bte  = '0;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] rdat;

    logic [31:0] ref_mem [WORDS];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_ram_burst #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_SIZE_BYTES(MEM),
        .WINDOW_WIDTH(24)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_adr_i(adr),
        .wb_dat_i(wdat),
        .wb_sel_i(sel),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_we_i(we),
        .wb_cti_i(cti),
        .wb_bte_i(bte),
        .wb_ack_o(ack),
        .wb_err_o(err),
        .wb_rty_o(rty),
        .wb_dat_o(rdat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Byte address of the next beat: +4 or wrap inside an aligned 4/8/16-word block.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b);
        int unsigned span;
        int unsigned base;
        if (b == 2'b00) return a + 32'd4;
        span = 4 * (2 << b);
        base = a - (a % span);
        return base + ((a - base + 4) % span);
    endfunction

    task automatic classic(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input string tag, output logic [31:0] rd);
        int lat;
        bit got;
        bit is_oor;
        is_oor = (a[23:0] >= 24'(MEM));
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        cti = 3'b000; bte = 2'b00;
        lat = 0; got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            got = ack || err;
        end
        chk({tag, " latency"}, lat, 2);
        rd = rdat;
        if (is_oor) begin
            chk({tag, " err"}, {31'b0, err}, 1);
            chk({tag, " ack"}, {31'b0, ack}, 0);
            chk({tag, " dat0"}, rdat, 0);
        end else begin
            chk({tag, " ack"}, {31'b0, ack}, 1);
            chk({tag, " err"}, {31'b0, err}, 0);
            if (!w) chk({tag, " data"}, rdat, ref_mem[widx(a)]);
            else model_wr(a, d, s);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, " idle"}, {30'b0, ack, err}, 0);
    endtask

    task automatic burst(input bit w, input logic [31:0] a0, input logic [1:0] b, input int n,
                         input bit rnd, input logic [31:0] dbase, input string tag);
        logic [31:0] a;
        logic [31:0] d;
        a = a0;
        d = rnd ? $urandom : dbase;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hf; bte = b; adr = a; wdat = d;
        cti = (n == 1) ? 3'b111 : 3'b010;
        @(negedge clk);
        chk({tag, " pre"}, {31'b0, ack}, 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({tag, " beat ack"}, {30'b0, ack, err}, 32'd2);
            if (!w) chk({tag, " beat data"}, rdat, ref_mem[widx(a)]);
            else ref_mem[widx(a)] = d;
            @(posedge clk); #1;
            if (k == n - 1) begin
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
            end else begin
                a = next_addr(a, b);
                d = rnd ? $urandom : dbase + 32'(k + 1);
                adr = a; wdat = d;
                cti = (k + 1 == n - 1) ? 3'b111 : 3'b010;
            end
        end
        @(negedge clk);
        chk({tag, " end"}, {30'b0, ack, err}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ack", {31'b0, ack}, 0);
        chk("rst err", {31'b0, err}, 0);
        chk("rst rty", {31'b0, rty}, 0);
        chk("rst dat", rdat, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        burst(1'b1, 32'h0, 2'b00, WORDS, 1'b1, 32'h0, "init");

        classic(1'b1, 32'h100, 32'hAABBCCDD, 4'b1111, "lane full", rd);
        classic(1'b1, 32'h100, 32'h11223344, 4'b0011, "lane part", rd);
        classic(1'b0, 32'h100, 32'h0, 4'hf, "lane rd", rd);
        chk("lane value", rd, 32'hAABB3344);

        burst(1'b1, 32'h0, 2'b00, 4, 1'b0, 32'h0, "lin pre");
        burst(1'b0, 32'h0, 2'b00, 4, 1'b0, 32'h0, "lin rd");

        burst(1'b1, 32'h8, 2'b01, 4, 1'b0, 32'hA000_0000, "wrap4 wr");
        burst(1'b0, 32'h8, 2'b01, 4, 1'b0, 32'h0, "wrap4 rd");
        classic(1'b0, 32'h0, 32'h0, 4'hf, "wrap4 m0", rd);
        chk("wrap4 m0 val", rd, 32'hA000_0002);
        classic(1'b0, 32'h4, 32'h0, 4'hf, "wrap4 m4", rd);
        chk("wrap4 m4 val", rd, 32'hA000_0003);
        classic(1'b0, 32'h8, 32'h0, 4'hf, "wrap4 m8", rd);
        chk("wrap4 m8 val", rd, 32'hA000_0000);
        classic(1'b0, 32'hC, 32'h0, 4'hf, "wrap4 mc", rd);
        chk("wrap4 mc val", rd, 32'hA000_0001);

        burst(1'b0, 32'h30, 2'b10, 10, 1'b0, 32'h0, "wrap8 rd");
        burst(1'b0, 32'h7C, 2'b11, 5, 1'b0, 32'h0, "wrap16 rd");

        classic(1'b0, 32'h400, 32'h0, 4'hf, "oor rd", rd);
        classic(1'b1, 32'h404, 32'hDEAD_BEEF, 4'hf, "oor wr", rd);

        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3FC; cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        chk("oorb pre", {31'b0, ack}, 0);
        @(negedge clk);
        chk("oorb b0 ack", {30'b0, ack, err}, 32'd2);
        chk("oorb b0 dat", rdat, ref_mem[WORDS-1]);
        @(posedge clk); #1;
        adr = 32'h400;
        @(negedge clk);
        chk("oorb b1 err", {30'b0, ack, err}, 32'd1);
        chk("oorb b1 dat", rdat, 0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("oorb after", {30'b0, ack, err}, 0);

        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("drop b0", rdat, ref_mem[0]);
        @(posedge clk); #1;
        adr = 32'h4;
        @(negedge clk);
        chk("drop b1 ack", {31'b0, ack}, 1);
        chk("drop b1", rdat, ref_mem[1]);
        @(posedge clk); #1;
        stb = 1'b0; adr = 32'h8;
        @(negedge clk);
        chk("drop ack", {31'b0, ack}, 0);
        @(posedge clk); #1;
        cyc = 1'b0;
        classic(1'b0, 32'h0, 32'h0, 4'hf, "drop rd", rd);

        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hf; adr = 32'h40; wdat = d0;
        cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rstb b0", {31'b0, ack}, 1);
        ref_mem[16] = d0;
        @(posedge clk); #1;
        adr = 32'h44; wdat = d1;
        @(negedge clk);
        chk("rstb b1", {31'b0, ack}, 1);
        ref_mem[17] = d1;
        @(posedge clk); #1;
        adr = 32'h48; wdat = d2; rst = 1'b1;
        @(negedge clk);
        chk("rstb b2", {31'b0, ack}, 1);
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("rstb outs", {30'b0, ack, err}, 0);
        chk("rstb dat", rdat, 0);
        classic(1'b0, 32'h40, 32'h0, 4'hf, "rstb m40", rd);
        classic(1'b0, 32'h44, 32'h0, 4'hf, "rstb m44", rd);
        classic(1'b0, 32'h48, 32'h0, 4'hf, "rstb m48", rd);

        for (int i = 0; i < 200; i++) begin
            int op;
            int w;
            int n;
            logic [1:0]  b;
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            op = $urandom_range(0, 4);
            w  = $urandom_range(0, WORDS - 1);
            a  = {8'($urandom), 14'b0, 8'(w), 2'b00};
            d  = $urandom;
            s  = 4'($urandom_range(1, 15));
            b  = 2'($urandom_range(0, 3));
            n  = $urandom_range(1, 8);
            case (op)
                0: classic(1'b1, a, d, s, "rnd wr", rd);
                1: classic(1'b0, a, d, 4'hf, "rnd rd", rd);
                2, 3: begin
                    if (b == 2'b00 && w > WORDS - n) w = WORDS - n;
                    burst(op == 3, {22'b0, 8'(w), 2'b00}, b, n, 1'b1, 32'h0, "rnd burst");
                end
                default: begin
                    a[23:0] = 24'($urandom_range(MEM, 32'hFF_FFFF)) & 24'hFF_FFFC;
                    classic(1'($urandom_range(0, 1)), a, d, s, "rnd oor", rd);
                end
            endcase
        end

        for (int k = 0; k < WORDS; k += 37) begin
            classic(1'b0, 32'(k * 4), 32'h0, 4'hf, "final rd", rd);
        end
        chk("final rty", {31'b0, rty}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
